// File: rtl/line_rasterizer.sv
// Sequential line rasterizer: walks the segment A->C and emits one pixel per
// accepted valid/ready transfer, matching the per-pixel on-line test
// (in_segment=1) including its tie-breaking toward the smaller minor coordinate.
module line_rasterizer #(
  parameter int WIDTH = 5
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_ax,
  input  logic [WIDTH-1:0] in_ay,
  input  logic [WIDTH-1:0] in_cx,
  input  logic [WIDTH-1:0] in_cy,
  input  logic             in_ready,
  output logic             out_busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_last,
  output logic             out_done
);

  localparam int EW = WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_EMIT
  } state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_ax;
  logic [WIDTH-1:0]       r_ay;
  logic [WIDTH-1:0]       r_cx;
  logic [WIDTH-1:0]       r_cy;
  logic                   r_steep;
  logic                   r_sx;      // 1: x decreases from A to C
  logic                   r_sy;      // 1: y decreases from A to C
  logic [WIDTH-1:0]       r_cnt;     // pixels remaining after the current one
  logic signed [EW-1:0]   r_err;
  logic signed [EW-1:0]   r_dmaj2;
  logic signed [EW-1:0]   r_dmin2;

  logic [WIDTH:0]         w_ddx;
  logic [WIDTH:0]         w_ddy;
  logic                   w_sx;
  logic                   w_sy;
  logic [WIDTH-1:0]       w_dx;
  logic [WIDTH-1:0]       w_dy;
  logic                   w_steep;
  logic [WIDTH-1:0]       w_dmaj;
  logic [WIDTH-1:0]       w_dmin;
  logic signed [EW-1:0]   w_dmaj_ext;
  logic signed [EW-1:0]   w_err0;

  logic signed [EW-1:0]   w_sum;
  logic                   w_minor_neg;
  logic                   w_pos;
  logic                   w_adv;
  logic signed [EW-1:0]   w_err_nx;
  logic [WIDTH-1:0]       w_x_step;
  logic [WIDTH-1:0]       w_y_step;
  logic [WIDTH-1:0]       w_x_nx;
  logic [WIDTH-1:0]       w_y_nx;

  // Setup datapath: deltas, step signs, major axis and initial error
  always_comb begin
    w_ddx      = {1'b0, r_cx} - {1'b0, r_ax};
    w_ddy      = {1'b0, r_cy} - {1'b0, r_ay};
    w_sx       = w_ddx[WIDTH];
    w_sy       = w_ddy[WIDTH];
    w_dx       = w_sx ? (~w_ddx[WIDTH-1:0] + 1'b1) : w_ddx[WIDTH-1:0];
    w_dy       = w_sy ? (~w_ddy[WIDTH-1:0] + 1'b1) : w_ddy[WIDTH-1:0];
    w_steep    = (w_dy > w_dx);
    w_dmaj     = w_steep ? w_dy : w_dx;
    w_dmin     = w_steep ? w_dx : w_dy;
    w_dmaj_ext = {{(EW-WIDTH){1'b0}}, w_dmaj};
    w_err0     = -w_dmaj_ext;
  end

  // Emit datapath: r_err = 2*k*dmin - (2*m+1)*dmaj for major step k and minor
  // offset m. After adding 2*dmin, a positive value means the ideal line is past
  // the midpoint; zero is an exact .5 tie, which advances the minor offset only
  // when the minor axis runs negative, so the smaller coordinate always wins.
  always_comb begin
    w_sum       = r_err + r_dmin2;
    w_minor_neg = r_steep ? r_sx : r_sy;
    w_pos       = !w_sum[EW-1] && (w_sum != '0);
    w_adv       = w_pos || ((w_sum == '0) && w_minor_neg);
    w_err_nx    = w_adv ? (w_sum - r_dmaj2) : w_sum;
    w_x_step    = r_sx ? (out_x - 1'b1) : (out_x + 1'b1);
    w_y_step    = r_sy ? (out_y - 1'b1) : (out_y + 1'b1);
    w_x_nx      = (!r_steep || w_adv) ? w_x_step : out_x;
    w_y_nx      = (r_steep || w_adv) ? w_y_step : out_y;
  end

  // Control FSM with registered stream outputs
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state   <= S_IDLE;
      r_ax      <= '0;
      r_ay      <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_steep   <= 1'b0;
      r_sx      <= 1'b0;
      r_sy      <= 1'b0;
      r_cnt     <= '0;
      r_err     <= '0;
      r_dmaj2   <= '0;
      r_dmin2   <= '0;
      out_busy  <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_start) begin
            r_ax     <= in_ax;
            r_ay     <= in_ay;
            r_cx     <= in_cx;
            r_cy     <= in_cy;
            out_busy <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_steep   <= w_steep;
          r_sx      <= w_sx;
          r_sy      <= w_sy;
          r_dmaj2   <= {{(EW-WIDTH-1){1'b0}}, w_dmaj, 1'b0};
          r_dmin2   <= {{(EW-WIDTH-1){1'b0}}, w_dmin, 1'b0};
          r_err     <= w_err0;
          r_cnt     <= w_dmaj;
          out_x     <= r_ax;
          out_y     <= r_ay;
          out_last  <= (w_dmaj == '0);
          out_valid <= 1'b1;
          r_state   <= S_EMIT;
        end
        S_EMIT: begin
          if (in_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_busy  <= 1'b0;
              out_done  <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              out_x    <= w_x_nx;
              out_y    <= w_y_nx;
              r_err    <= w_err_nx;
              r_cnt    <= r_cnt - 1'b1;
              // The pixel count along the major axis reaches C exactly when
              // one step remains, so out_last needs no coordinate compare.
              out_last <= (r_cnt == WIDTH'(1));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: directed vector table, backpressure,
// reset abort and a grid cross-check against an independent on-line test model.
module tb_line_rasterizer;

  typedef logic [0:7][4:0] coords_t;

  typedef struct {
    logic [4:0] ax;
    logic [4:0] ay;
    logic [4:0] cx;
    logic [4:0] cy;
    int         npix;
    coords_t    ex;
    coords_t    ey;
  } vec_t;

  logic       in_clk = 1'b0;
  logic       in_rst;
  logic       in_start;
  logic [4:0] in_ax;
  logic [4:0] in_ay;
  logic [4:0] in_cx;
  logic [4:0] in_cy;
  logic       in_ready;
  logic       out_busy;
  logic       out_valid;
  logic [4:0] out_x;
  logic [4:0] out_y;
  logic       out_last;
  logic       out_done;

  int checks   = 0;
  int failures = 0;
  int qx[$];
  int qy[$];
  int ncyc;
  vec_t tbl[6];

  line_rasterizer #(.WIDTH(5)) dut (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_start (in_start),
    .in_ax    (in_ax),
    .in_ay    (in_ay),
    .in_cx    (in_cx),
    .in_cy    (in_cy),
    .in_ready (in_ready),
    .out_busy (out_busy),
    .out_valid(out_valid),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_last (out_last),
    .out_done (out_done)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Independent on-line test: nearest minor value per major value, exact ties
  // to the numerically smaller coordinate.
  function automatic bit online(input int x, input int y, input int ax, input int ay,
                                input int cx, input int cy);
    int dx, dy, k, dmaj, dmin, base, dir, actual, num, m;
    bit pos;
    dx = (cx > ax) ? cx - ax : ax - cx;
    dy = (cy > ay) ? cy - ay : ay - cy;
    if (x < ((ax < cx) ? ax : cx) || x > ((ax > cx) ? ax : cx)) return 1'b0;
    if (y < ((ay < cy) ? ay : cy) || y > ((ay > cy) ? ay : cy)) return 1'b0;
    if (dy > dx) begin
      k = (y > ay) ? y - ay : ay - y;
      dmaj = dy; dmin = dx; pos = (cx > ax); base = ax;
      dir = (cx >= ax) ? 1 : -1; actual = x;
    end else begin
      k = (x > ax) ? x - ax : ax - x;
      dmaj = dx; dmin = dy; pos = (cy > ay); base = ay;
      dir = (cy >= ay) ? 1 : -1; actual = y;
    end
    if (dmaj == 0) return 1'b1;
    num = 2 * k * dmin;
    m = (num + dmaj) / (2 * dmaj);
    if ((num % (2 * dmaj)) == dmaj && pos) m = m - 1;
    return actual == base + dir * m;
  endfunction

  // Start one line and collect transferred pixels into qx/qy
  task automatic run_line(input int ax_i, input int ay_i, input int cx_i, input int cy_i,
                          input bit bp);
    logic pv, pl, pr;
    logic [4:0] px, py;
    bit fin;
    qx.delete();
    qy.delete();
    in_ax = 5'(ax_i); in_ay = 5'(ay_i); in_cx = 5'(cx_i); in_cy = 5'(cy_i);
    in_start = 1'b1;
    in_ready = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    ncyc = 1;
    chk("busy_setup", int'(out_busy), 1);
    chk("valid_setup", int'(out_valid), 0);
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      in_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_start = (bp && out_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bp) begin
        in_ax = 5'($urandom); in_cy = 5'($urandom);
      end
      pv = out_valid; pl = out_last; px = out_x; py = out_y; pr = in_ready;
      @(posedge in_clk); #1;
      ncyc++;
      if (pv && pr) begin
        qx.push_back(int'(px));
        qy.push_back(int'(py));
        chk("last_flag", int'(pl), int'(int'(px) == cx_i && int'(py) == cy_i));
        if (pl) begin
          chk("done_pulse", int'(out_done), 1);
          chk("valid_drop", int'(out_valid), 0);
          chk("busy_drop", int'(out_busy), 0);
          fin = 1'b1;
        end else begin
          chk("no_early_done", int'(out_done), 0);
        end
      end else if (pv) begin
        chk("stall_x", int'(out_x), int'(px));
        chk("stall_y", int'(out_y), int'(py));
        chk("stall_last", int'(out_last), int'(pl));
        chk("stall_valid", int'(out_valid), 1);
      end else begin
        chk("valid_emit", int'(out_valid), 1);
      end
    end
    in_start = 1'b0;
    in_ready = 1'b0;
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL line_timeout: got no final transfer expected one within 400 cycles");
    end
    @(posedge in_clk); #1;
    chk("done_one_cycle", int'(out_done), 0);
  endtask

  task automatic grid_check(input int ax_i, input int ay_i, input int cx_i, input int cy_i);
    bit g[32][32];
    int dup, mism;
    dup = 0; mism = 0;
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++) g[x][y] = 1'b0;
    for (int i = 0; i < qx.size(); i++) begin
      if (g[qx[i]][qy[i]]) dup++;
      g[qx[i]][qy[i]] = 1'b1;
    end
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        if (g[x][y] != online(x, y, ax_i, ay_i, cx_i, cy_i)) mism++;
    chk("xchk_mismatch_cells", mism, 0);
    chk("xchk_repeats", dup, 0);
    if (qx.size() > 0) begin
      chk("xchk_first_x", qx[0], ax_i);
      chk("xchk_first_y", qy[0], ay_i);
    end else begin
      chk("xchk_nonempty", 0, 1);
    end
  endtask

  initial begin
    int t, a0, a1, c0, c1;
    logic pv;

    tbl[0] = '{5'd2, 5'd3, 5'd6, 5'd3, 5,
               {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0},
               {5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0}};
    tbl[1] = '{5'd0, 5'd0, 5'd2, 5'd5, 6,
               {5'd0, 5'd0, 5'd1, 5'd1, 5'd2, 5'd2, 5'd0, 5'd0},
               {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd0, 5'd0}};
    tbl[2] = '{5'd0, 5'd0, 5'd4, 5'd2, 5,
               {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0},
               {5'd0, 5'd0, 5'd1, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0}};
    tbl[3] = '{5'd4, 5'd2, 5'd0, 5'd0, 5,
               {5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0},
               {5'd2, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
    tbl[4] = '{5'd7, 5'd9, 5'd7, 5'd9, 1,
               {5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               {5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
    tbl[5] = '{5'd5, 5'd1, 5'd0, 5'd3, 6,
               {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0},
               {5'd1, 5'd1, 5'd2, 5'd2, 5'd3, 5'd3, 5'd0, 5'd0}};

    in_rst = 1'b1; in_start = 1'b0; in_ready = 1'b0;
    in_ax = '0; in_ay = '0; in_cx = '0; in_cy = '0;
    repeat (2) @(posedge in_clk);
    #1;
    chk("rst_busy", int'(out_busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_done", int'(out_done), 0);
    chk("rst_x", int'(out_x), 0);
    chk("rst_y", int'(out_y), 0);
    in_rst = 1'b0;
    @(posedge in_clk); #1;

    // Directed vectors with in_ready held high
    for (int i = 0; i < 6; i++) begin
      run_line(int'(tbl[i].ax), int'(tbl[i].ay), int'(tbl[i].cx), int'(tbl[i].cy), 1'b0);
      chk($sformatf("v%0d_npix", i), qx.size(), tbl[i].npix);
      chk($sformatf("v%0d_cycles", i), ncyc, tbl[i].npix + 2);
      for (int k = 0; k < tbl[i].npix && k < qx.size(); k++) begin
        chk($sformatf("v%0d_x%0d", i, k), qx[k], int'(tbl[i].ex[k]));
        chk($sformatf("v%0d_y%0d", i, k), qy[k], int'(tbl[i].ey[k]));
      end
    end

    // Random backpressure and ignored in_start on the full anti-diagonal
    run_line(31, 0, 0, 31, 1'b1);
    chk("bp_npix", qx.size(), 32);
    for (int k = 0; k < 32 && k < qx.size(); k++) begin
      chk($sformatf("bp_x%0d", k), qx[k], 31 - k);
      chk($sformatf("bp_y%0d", k), qy[k], k);
    end

    // Reset in the middle of a line
    in_ax = 5'd0; in_ay = 5'd0; in_cx = 5'd20; in_cy = 5'd5;
    in_start = 1'b1; in_ready = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    t = 0;
    for (int c = 0; c < 50 && t < 3; c++) begin
      pv = out_valid;
      @(posedge in_clk); #1;
      if (pv) t++;
    end
    chk("mid_transfers", t, 3);
    chk("mid_x", int'(out_x), 3);
    chk("mid_y", int'(out_y), 1);
    in_rst = 1'b1;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    chk("midrst_busy", int'(out_busy), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_last", int'(out_last), 0);
    chk("midrst_done", int'(out_done), 0);
    chk("midrst_x", int'(out_x), 0);
    chk("midrst_y", int'(out_y), 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge in_clk); #1;
      chk("midrst_no_done", int'(out_done), 0);
      chk("midrst_idle_valid", int'(out_valid), 0);
    end
    in_ready = 1'b0;

    // Grid cross-check against the on-line test, both directions
    for (int i = 0; i < 6; i++) begin
      a0 = $urandom_range(1, 30); a1 = $urandom_range(1, 30);
      c0 = $urandom_range(1, 30); c1 = $urandom_range(1, 30);
      run_line(a0, a1, c0, c1, 1'b0);
      grid_check(a0, a1, c0, c1);
      run_line(c0, c1, a0, a1, 1'b0);
      grid_check(c0, c1, a0, a1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
